// File: rtl/cart_pkg.sv
// Shared cartridge-loader types and the address-mask helper used by the
// loader and by the core's cartridge address decode.
package cart_pkg;

    localparam int MAX_SLOTS = 8;
    localparam int IOCTL_AW  = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } loader_state_t;

    // Smallest 2^n-1 that covers addr: OR of every right shift of addr.
    function automatic logic [IOCTL_AW-1:0] smear_mask(input logic [IOCTL_AW-1:0] addr);
        logic [IOCTL_AW-1:0] m;
        m = addr;
        for (int i = 1; i < IOCTL_AW; i++) m = m | (addr >> i);
        return m;
    endfunction

endpackage

// File: rtl/cart_wbuf.sv
// One-entry request/ack write buffer. The owner only raises load when the
// entry is empty or is being acked the same cycle, so a load always wins
// over an ack and the entry refills back-to-back.
module cart_wbuf #(
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              ack,
    input  logic [2:0]        i_slot,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic              full,
    output logic [2:0]        o_slot,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data
);

    logic              r_full;
    logic [2:0]        r_slot;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;

    // Entry occupancy and payload; refill on ack keeps full high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_slot <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_slot <= i_slot;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (ack) begin
            r_full <= 1'b0;
        end
    end

    assign full   = r_full;
    assign o_slot = r_slot;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

// File: rtl/cart_loader.sv
// Multi-slot cartridge loader: captures HPS ioctl download bytes into a
// one-entry write buffer and tracks per-slot mask, size and status flags.
import cart_pkg::*;

module cart_loader #(
    parameter int ADDR_W = 15,
    parameter int SLOTS  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ioctl_download,
    input  logic [7:0]                    ioctl_index,
    input  logic                          ioctl_wr,
    input  logic [24:0]                   ioctl_addr,
    input  logic [7:0]                    ioctl_dout,
    output logic                          ioctl_wait,
    output logic                          mem_req,
    input  logic                          mem_ack,
    output logic [2:0]                    mem_slot,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [7:0]                    mem_data,
    output logic [SLOTS-1:0][ADDR_W-1:0]  slot_mask,
    output logic [SLOTS-1:0][ADDR_W:0]    slot_size,
    output logic [SLOTS-1:0]              slot_valid,
    output logic [SLOTS-1:0]              overflow,
    output logic                          proto_err,
    output logic                          busy
);

    loader_state_t r_state;
    logic          r_dl_d;
    logic [2:0]    r_slot;
    logic          r_active;
    logic          r_perr;

    logic [SLOTS-1:0][ADDR_W-1:0] r_mask;
    logic [SLOTS-1:0][ADDR_W:0]   r_size;
    logic [SLOTS-1:0]             r_valid;
    logic [SLOTS-1:0]             r_ovf;

    logic              w_full;
    logic              w_rise;
    logic [2:0]        w_new_slot;
    logic              w_new_ok;
    logic              w_clr;
    logic              w_wr;
    logic              w_in_range;
    logic              w_can_load;
    logic              w_load;
    logic              w_ovf;
    logic              w_perr;
    logic              w_done;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_smear;
    logic [ADDR_W:0]   w_size_new;
    logic              w_unused;

    assign w_rise     = ioctl_download & ~r_dl_d;
    assign w_new_slot = ioctl_index[2:0];
    assign w_new_ok   = ({1'b0, w_new_slot} < 4'(SLOTS));
    assign w_clr      = (r_state == IDLE) & w_rise & w_new_ok;

    // Writes only count inside a window aimed at an existing slot.
    assign w_wr       = (r_state == LOAD) & r_active & ioctl_wr;
    assign w_in_range = ((ioctl_addr >> ADDR_W) == '0);
    assign w_can_load = ~w_full | mem_ack;
    assign w_load     = w_wr & w_in_range & w_can_load;
    assign w_ovf      = w_wr & ~w_in_range;
    assign w_perr     = w_wr & w_in_range & ~w_can_load;
    assign w_done     = (r_state == FLUSH) & ~w_full;

    // High address bits only feed the overflow check, never mem_addr.
    assign w_addr     = ioctl_addr[ADDR_W-1:0];
    assign w_smear    = ADDR_W'(smear_mask(ioctl_addr));
    assign w_size_new = {1'b0, w_addr} + (ADDR_W+1)'(1);
    assign w_unused   = ^ioctl_index[7:3];

    cart_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
        .clock  (clock),
        .reset  (reset),
        .load   (w_load),
        .ack    (mem_ack),
        .i_slot (r_slot),
        .i_addr (w_addr),
        .i_data (ioctl_dout),
        .full   (w_full),
        .o_slot (mem_slot),
        .o_addr (mem_addr),
        .o_data (mem_data)
    );

    // Download FSM: window edges, target slot latch, sticky protocol error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_dl_d   <= 1'b0;
            r_slot   <= '0;
            r_active <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_dl_d <= ioctl_download;
            if (w_perr) r_perr <= 1'b1;
            case (r_state)
                IDLE: if (w_rise) begin
                    r_state  <= LOAD;
                    r_slot   <= w_new_slot;
                    r_active <= w_new_ok;
                end
                LOAD:    if (!ioctl_download) r_state <= FLUSH;
                FLUSH:   if (!w_full) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-slot mask/size/valid/overflow; a new window clears only its slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask  <= '0;
            r_size  <= '0;
            r_valid <= '0;
            r_ovf   <= '0;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_clr && w_new_slot == 3'(s)) begin
                    r_mask[s]  <= '0;
                    r_size[s]  <= '0;
                    r_valid[s] <= 1'b0;
                    r_ovf[s]   <= 1'b0;
                end else if (r_active && r_slot == 3'(s)) begin
                    if (w_load) begin
                        r_mask[s] <= r_mask[s] | w_smear;
                        if (w_size_new > r_size[s]) r_size[s] <= w_size_new;
                    end
                    if (w_ovf)  r_ovf[s]   <= 1'b1;
                    if (w_done) r_valid[s] <= (r_size[s] != '0);
                end
            end
        end
    end

    assign mem_req    = w_full;
    assign ioctl_wait = w_full;
    assign slot_mask  = r_mask;
    assign slot_size  = r_size;
    assign slot_valid = r_valid;
    assign overflow   = r_ovf;
    assign proto_err  = r_perr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cart_loader.sv
// Directed + randomized bench for cart_loader against a slot-level model.
module tb_cart_loader;

    localparam int AW = 15;
    localparam int NS = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      ioctl_download = 1'b0;
    logic [7:0]                ioctl_index = '0;
    logic                      ioctl_wr = 1'b0;
    logic [24:0]               ioctl_addr = '0;
    logic [7:0]                ioctl_dout = '0;
    logic                      ioctl_wait;
    logic                      mem_req;
    logic                      mem_ack = 1'b0;
    logic [2:0]                mem_slot;
    logic [AW-1:0]             mem_addr;
    logic [7:0]                mem_data;
    logic [NS-1:0][AW-1:0]     slot_mask;
    logic [NS-1:0][AW:0]       slot_size;
    logic [NS-1:0]             slot_valid;
    logic [NS-1:0]             overflow;
    logic                      proto_err;
    logic                      busy;

    cart_loader #(.ADDR_W(AW), .SLOTS(NS)) dut (
        .clock(clock), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_slot(mem_slot), .mem_addr(mem_addr),
        .mem_data(mem_data), .slot_mask(slot_mask), .slot_size(slot_size),
        .slot_valid(slot_valid), .overflow(overflow), .proto_err(proto_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // memory-side ack: 0 = held low, 1 = tied high, 2 = ack 3 cycles after req
    int ack_mode = 0;
    int dcnt = 0;
    always @(posedge clock) begin
        #1;
        if (ack_mode == 1) mem_ack = 1'b1;
        else if (ack_mode == 2) begin
            if (mem_req && !mem_ack) begin
                if (dcnt == 2) begin mem_ack = 1'b1; dcnt = 0; end
                else dcnt++;
            end else mem_ack = 1'b0;
        end else mem_ack = 1'b0;
    end

    // observed write beats and wait activity, sampled mid-cycle
    logic [25:0] got[$];
    int          wait_cnt = 0;
    always @(negedge clock) begin
        if (mem_req && mem_ack) got.push_back({mem_slot, mem_addr, mem_data});
        if (ioctl_wait === 1'b1) wait_cnt++;
    end

    // slot-level model
    logic [25:0] exp_q[$];
    int gbase = 0;
    int m_max[NS];
    bit m_valid[NS];
    bit m_ovf[NS];
    bit m_perr = 0;
    int cur_slot = 0;
    bit cur_active = 0;

    function automatic int ref_mask(input int mx);
        int m = 0;
        if (mx < 0) return 0;
        while (m < mx) m = m * 2 + 1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        assert (got_v === exp_v) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic start_dl(input int idx);
        tick();
        ioctl_index = 8'(idx);
        ioctl_download = 1'b1;
        cur_slot = idx;
        cur_active = (idx < NS);
        if (cur_active) begin
            m_max[idx] = -1; m_valid[idx] = 0; m_ovf[idx] = 0;
        end
        tick();
    endtask

    // ok=0 marks a byte the model expects the loader to reject (buffer busy)
    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit honour, input bit ok);
        int n = 0;
        if (honour) begin
            while (ioctl_wait === 1'b1 && n < 100) begin tick(); n++; end
            chk("wait bound", 32'(n < 100), 32'd1);
        end
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        if (cur_active) begin
            if (a >= 25'h8000) m_ovf[cur_slot] = 1;
            else if (ok) begin
                exp_q.push_back({3'(cur_slot), a[AW-1:0], d});
                if (int'(a) > m_max[cur_slot]) m_max[cur_slot] = int'(a);
            end else m_perr = 1;
        end
    endtask

    task automatic end_dl();
        int n = 0;
        ioctl_download = 1'b0;
        if (cur_active) m_valid[cur_slot] = (m_max[cur_slot] >= 0);
        tick();
        while (busy === 1'b1 && n < 200) begin tick(); n++; end
        chk("flush bound", 32'(n < 200), 32'd1);
        repeat (2) tick();
    endtask

    task automatic check_slots(input string tag);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("%s mask%0d", tag, s), 32'(slot_mask[s]), 32'(ref_mask(m_max[s])));
            chk($sformatf("%s size%0d", tag, s), 32'(slot_size[s]), 32'(m_max[s] + 1));
            chk($sformatf("%s valid%0d", tag, s), 32'(slot_valid[s]), 32'(m_valid[s]));
            chk($sformatf("%s ovf%0d", tag, s), 32'(overflow[s]), 32'(m_ovf[s]));
        end
        chk({tag, " perr"}, 32'(proto_err), 32'(m_perr));
    endtask

    task automatic check_beats(input string tag);
        int first = -1;
        chk({tag, " beats"}, 32'(got.size() - gbase), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (first < 0 && (gbase + i >= got.size() || got[gbase + i] !== exp_q[i])) first = i;
        chk({tag, " order"}, 32'(first), 32'hFFFF_FFFF);
        gbase = got.size();
        exp_q.delete();
    endtask

    int perm[3000];
    int w0;
    int lim;

    initial begin
        for (int s = 0; s < NS; s++) begin m_max[s] = -1; m_valid[s] = 0; m_ovf[s] = 0; end

        // reset state
        #12;
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst wait", 32'(ioctl_wait), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst addr", 32'(mem_addr), 0);
        check_slots("rst");
        tick();
        reset = 1'b0;
        tick();

        // basic 8 KiB load, back-to-back with ack tied high
        ack_mode = 1;
        start_dl(0);
        for (int i = 0; i < 8192; i++) wr(25'(i), 8'($urandom), 1'b0, 1'b1);
        end_dl();
        check_beats("basic");
        check_slots("basic");
        chk("basic mask lit", 32'(slot_mask[0]), 32'h1FFF);
        chk("basic size lit", 32'(slot_size[0]), 32'd8192);

        // odd size, shuffled address order, slot 1
        for (int i = 0; i < 3000; i++) perm[i] = i;
        for (int i = 2999; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        start_dl(1);
        for (int i = 0; i < 3000; i++) wr(25'(perm[i]), 8'($urandom), 1'b0, 1'b1);
        end_dl();
        check_beats("odd");
        check_slots("odd");
        chk("odd mask lit", 32'(slot_mask[1]), 32'h0FFF);

        // backpressure: slow ack, HPS honours ioctl_wait
        ack_mode = 2;
        lim = int'($urandom_range(64, 32767));
        start_dl(0);
        for (int i = 0; i < 40; i++) wr(25'($urandom_range(0, lim)), 8'($urandom), 1'b1, 1'b1);
        end_dl();
        check_beats("bp");
        check_slots("bp");

        // overflow on slot 1; slot 0 must be untouched
        ack_mode = 1;
        start_dl(1);
        wr(25'h8000, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) wr(25'($urandom_range(32'h8000, 32'h1FF_FFFF)), 8'($urandom), 1'b0, 1'b1);
        end_dl();
        check_beats("ovf");
        check_slots("ovf");

        // window aimed at a non-existent slot is ignored entirely
        w0 = wait_cnt;
        start_dl(5);
        for (int i = 0; i < 4; i++) wr(25'($urandom_range(0, 32767)), 8'($urandom), 1'b0, 1'b1);
        end_dl();
        chk("ign wait", 32'(wait_cnt - w0), 0);
        check_beats("ign");
        check_slots("ign");

        // protocol violation: second byte while full and not acked
        ack_mode = 0;
        start_dl(1);
        wr(25'($urandom_range(0, 32767)), 8'($urandom), 1'b0, 1'b1);
        wr(25'($urandom_range(0, 32767)), 8'($urandom), 1'b0, 1'b0);
        chk("perr sticky", 32'(proto_err), 32'd1);
        chk("perr held", 32'(mem_req), 32'd1);
        ack_mode = 1;
        end_dl();
        check_beats("perr");
        check_slots("perr");

        // reset mid-image with one byte pending
        start_dl(0);
        for (int i = 0; i < 99; i++) wr(25'(i), 8'($urandom), 1'b0, 1'b1);
        for (int n = 0; n < 20 && mem_req === 1'b1; n++) tick();
        ack_mode = 0;
        repeat (2) tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'd99; ioctl_dout = 8'($urandom);
        tick();
        ioctl_wr = 1'b0;
        chk("mid pending", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        for (int s = 0; s < NS; s++) begin m_max[s] = -1; m_valid[s] = 0; m_ovf[s] = 0; end
        m_perr = 0;
        chk("mid req", 32'(mem_req), 0);
        chk("mid wait", 32'(ioctl_wait), 0);
        chk("mid busy", 32'(busy), 0);
        chk("mid data", 32'({mem_slot, mem_addr, mem_data}), 0);
        check_slots("mid");
        exp_q.delete();
        for (int i = 0; i < 99; i++) exp_q.push_back(got[gbase + i]);
        gbase = gbase + 99;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("post busy", 32'(busy), 0);
        chk("post req", 32'(mem_req), 0);
        check_slots("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
